// File: rtl/counter_bcd_pkg.sv
// Shared BCD types, digit bounds and LIMIT-to-BCD helpers.
// Used by counter_bcd_multi and bcd_digit.
package counter_bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;
  localparam int unsigned MAX_DIGITS = 8;

  // Decimal value to packed BCD, up to eight digits.
  function automatic logic [31:0] to_bcd(
    input int unsigned val
  );
    logic [31:0] r;
    int unsigned v;
    r = '0;
    v = val;
    for (int k = 0; k < MAX_DIGITS; k++) begin
      r[4*k +: 4] = 4'(v % 32'd10);
      v = v / 32'd10;
    end
    return r;
  endfunction

  // 10^n, used for the legal LIMIT range.
  function automatic int unsigned pow10(
    input int unsigned n
  );
    int unsigned r;
    r = 1;
    for (int unsigned k = 0; k < n; k++) begin
      r = r * 32'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit cell: steps the digit when carry/borrow is in,
// wraps at wrap_i (up) or reloads wrap_i below zero (down).
module bcd_digit
  import counter_bcd_pkg::*;
(
  input  bcd_digit_t d_i,
  input  logic       cin_i,
  input  bcd_digit_t wrap_i,
  input  logic       up_i,
  output bcd_digit_t d_o,
  output logic       cout_o
);

  // Next digit and carry/borrow out of this cell.
  always_comb begin
    d_o    = d_i;
    cout_o = 1'b0;
    if (cin_i) begin
      if (up_i) begin
        if (d_i >= wrap_i) begin
          d_o    = BCD_MIN;
          cout_o = 1'b1;
        end else begin
          d_o = d_i + 4'd1;
        end
      end else begin
        if (d_i == BCD_MIN) begin
          d_o    = wrap_i;
          cout_o = 1'b1;
        end else begin
          d_o = d_i - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/counter_bcd_multi.sv
// Multi-digit BCD counter with terminal LIMIT, load and wrap pulse.
// Define COUNTER_BCD_DOWN_EN to add up_dn and down counting.
module counter_bcd_multi
  import counter_bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int LIMIT  = 9999
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
`ifdef COUNTER_BCD_DOWN_EN
  input  logic                up_dn,
`endif
  output logic [4*DIGITS-1:0] bcd,
  output logic                tc,
  output logic                carry_out,
  output logic                load_err
);

  localparam int W = 4 * DIGITS;
  localparam logic [31:0] LIMIT_ALL =
    to_bcd(LIMIT);
  localparam logic [W-1:0] LIMIT_BCD =
    LIMIT_ALL[W-1:0];

  if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
    $fatal(1, "DIGITS out of range 1..8");
  end
  if (LIMIT < 1 ||
      $unsigned(LIMIT) > pow10(DIGITS) - 1)
  begin : g_bad_limit
    $fatal(1, "LIMIT out of range");
  end

  logic         up;
  logic [W-1:0] count_q, count_d;
  logic [W-1:0] step_nxt;
  logic [DIGITS:0] chain;
  logic         tc_q, tc_d;
  logic         carry_q, carry_d;
  logic         lerr_q, lerr_d;
  logic         digits_ok;
  logic         load_ok;
  logic         at_term;

`ifdef COUNTER_BCD_DOWN_EN
  assign up = up_dn;
`else
  assign up = 1'b1;
`endif

  assign chain[0] = 1'b1;

  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    bcd_digit u_dig (
      .d_i    (count_q[4*k +: 4]),
      .cin_i  (chain[k]),
      .wrap_i (BCD_MAX),
      .up_i   (up),
      .d_o    (step_nxt[4*k +: 4]),
      .cout_o (chain[k+1])
    );
  end

  // Load legality: every digit BCD and value within LIMIT.
  always_comb begin
    digits_ok = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (load_val[4*k +: 4] > BCD_MAX) begin
        digits_ok = 1'b0;
      end
    end
    load_ok = digits_ok && (load_val <= LIMIT_BCD);
  end

  // Next count, wrap pulse, load error and terminal flag.
  always_comb begin
    count_d = count_q;
    carry_d = 1'b0;
    lerr_d  = 1'b0;
    at_term = up ? (count_q == LIMIT_BCD)
                 : chain[DIGITS];
    if (load) begin
      if (load_ok) begin
        count_d = load_val;
      end else begin
        lerr_d = 1'b1;
      end
    end else if (enable) begin
      if (at_term) begin
        count_d = up ? '0 : LIMIT_BCD;
        carry_d = 1'b1;
      end else begin
        count_d = step_nxt;
      end
    end
    tc_d = up ? (count_d == LIMIT_BCD)
              : (count_d == '0);
  end

  // State update on the falling edge, synchronous reset.
  always_ff @(negedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
      tc_q    <= ~up;
      carry_q <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      carry_q <= carry_d;
      lerr_q  <= lerr_d;
    end
  end

  assign bcd       = count_q;
  assign tc        = tc_q;
  assign carry_out = carry_q;
  assign load_err  = lerr_q;

endmodule

// File: tb/tb_counter_bcd_multi.sv
// Directed bench: 2-digit LIMIT=59 and 4-digit LIMIT=9999 counters.
// Down-count steps run when COUNTER_BCD_DOWN_EN is defined.
module tb_counter_bcd_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic       a_rst_n, a_en, a_ld;
  logic [7:0] a_lv, a_bcd;
  logic       a_tc, a_co, a_le;
  logic        b_rst_n, b_en, b_ld;
  logic [15:0] b_lv, b_bcd;
  logic        b_tc, b_co, b_le;
`ifdef COUNTER_BCD_DOWN_EN
  logic a_up = 1'b1;
  logic b_up = 1'b1;
`endif

  counter_bcd_multi #(.DIGITS(2), .LIMIT(59)) u_a (
    .clk       (clk),
    .reset_n   (a_rst_n),
    .enable    (a_en),
    .load      (a_ld),
    .load_val  (a_lv),
`ifdef COUNTER_BCD_DOWN_EN
    .up_dn     (a_up),
`endif
    .bcd       (a_bcd),
    .tc        (a_tc),
    .carry_out (a_co),
    .load_err  (a_le)
  );

  counter_bcd_multi #(.DIGITS(4), .LIMIT(9999)) u_b (
    .clk       (clk),
    .reset_n   (b_rst_n),
    .enable    (b_en),
    .load      (b_ld),
    .load_val  (b_lv),
`ifdef COUNTER_BCD_DOWN_EN
    .up_dn     (b_up),
`endif
    .bcd       (b_bcd),
    .tc        (b_tc),
    .carry_out (b_co),
    .load_err  (b_le)
  );

  task automatic tick();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_a(
    input string      tag,
    input logic [7:0] e_bcd,
    input logic       e_tc,
    input logic       e_co,
    input logic       e_le
  );
    check({tag, ".bcd"}, 32'(a_bcd), 32'(e_bcd));
    check({tag, ".tc"},  32'(a_tc),  32'(e_tc));
    check({tag, ".co"},  32'(a_co),  32'(e_co));
    check({tag, ".le"},  32'(a_le),  32'(e_le));
  endtask

  initial begin
    logic [7:0] e;
    a_rst_n = 1'b0; a_en = 1'b0;
    a_ld = 1'b0; a_lv = 8'h00;
    b_rst_n = 1'b0; b_en = 1'b0;
    b_ld = 1'b0; b_lv = 16'h0000;
    @(posedge clk);
    tick();
    chk_a("rst", 8'h00, 1'b0, 1'b0, 1'b0);
    check("b_rst", 32'(b_bcd), 32'h0);

    a_rst_n = 1'b1; b_rst_n = 1'b1;
    a_en = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      e = (i == 60) ? 8'h00
          : {4'(i / 10), 4'(i % 10)};
      check($sformatf("cnt%0d.bcd", i),
            32'(a_bcd), 32'(e));
      check($sformatf("cnt%0d.co", i),
            32'(a_co), 32'(i == 60));
      check($sformatf("cnt%0d.tc", i),
            32'(a_tc), 32'(i == 59));
    end

    a_en = 1'b0;
    tick();
    chk_a("hold", 8'h00, 1'b0, 1'b0, 1'b0);

    a_ld = 1'b1; a_lv = 8'h1A;
    tick();
    chk_a("ld1A", 8'h00, 1'b0, 1'b0, 1'b1);
    a_ld = 1'b0;
    tick();
    chk_a("ld1A_after", 8'h00, 1'b0, 1'b0, 1'b0);
    a_ld = 1'b1; a_lv = 8'h75;
    tick();
    chk_a("ld75", 8'h00, 1'b0, 1'b0, 1'b1);
    a_lv = 8'h42;
    tick();
    chk_a("ld42", 8'h42, 1'b0, 1'b0, 1'b0);
    a_lv = 8'h59;
    tick();
    chk_a("ld59", 8'h59, 1'b1, 1'b0, 1'b0);
    a_lv = 8'h37;
    tick();
    chk_a("ld37", 8'h37, 1'b0, 1'b0, 1'b0);

    a_rst_n = 1'b0; a_lv = 8'h12; a_en = 1'b1;
    tick();
    chk_a("rst_ld_en", 8'h00, 1'b0, 1'b0, 1'b0);
    a_rst_n = 1'b1; a_ld = 1'b0;
    tick();
    chk_a("post_rst", 8'h01, 1'b0, 1'b0, 1'b0);

    a_ld = 1'b1; a_lv = 8'h10;
    tick();
    chk_a("ld_en", 8'h10, 1'b0, 1'b0, 1'b0);
    a_ld = 1'b0; a_en = 1'b0;
    tick();
    chk_a("ld_en_hold", 8'h10, 1'b0, 1'b0, 1'b0);

`ifdef COUNTER_BCD_DOWN_EN
    a_ld = 1'b1; a_lv = 8'h00;
    tick();
    a_ld = 1'b0; a_up = 1'b0;
    tick();
    chk_a("dn_tc", 8'h00, 1'b1, 1'b0, 1'b0);
    a_en = 1'b1;
    tick();
    chk_a("dn_wrap", 8'h59, 1'b0, 1'b1, 1'b0);
    tick();
    chk_a("dn_58", 8'h58, 1'b0, 1'b0, 1'b0);
    a_en = 1'b0; a_ld = 1'b1; a_lv = 8'h10;
    tick();
    a_ld = 1'b0; a_en = 1'b1;
    tick();
    chk_a("dn_09", 8'h09, 1'b0, 1'b0, 1'b0);
    a_en = 1'b0; a_rst_n = 1'b0;
    tick();
    chk_a("dn_rst", 8'h00, 1'b1, 1'b0, 1'b0);
    a_rst_n = 1'b1; a_up = 1'b1;
    tick();
    chk_a("up_tc", 8'h00, 1'b0, 1'b0, 1'b0);
`endif

    b_ld = 1'b1; b_lv = 16'h0199;
    tick();
    check("b_ld0199", 32'(b_bcd), 32'h0199);
    b_ld = 1'b0; b_en = 1'b1;
    tick();
    check("b_0200", 32'(b_bcd), 32'h0200);
    check("b_0200.co", 32'(b_co), 32'h0);
    b_en = 1'b0; b_ld = 1'b1; b_lv = 16'h9999;
    tick();
    check("b_9999.tc", 32'(b_tc), 32'h1);
    b_ld = 1'b0; b_en = 1'b1;
    tick();
    check("b_wrap", 32'(b_bcd), 32'h0000);
    check("b_wrap.co", 32'(b_co), 32'h1);
    check("b_wrap.tc", 32'(b_tc), 32'h0);
    b_en = 1'b0; b_ld = 1'b1; b_lv = 16'h00A0;
    tick();
    check("b_ldA0", 32'(b_bcd), 32'h0000);
    check("b_ldA0.le", 32'(b_le), 32'h1);
    b_ld = 1'b0;
    tick();
    check("b_ldA0_after.le", 32'(b_le), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
